// File: rtl/disp_page_mux_pkg.sv
// Shared page indices, widths and defaults for the display-page sequencer.
package disp_page_mux_pkg;

    localparam int unsigned PAGE_W    = 2;
    localparam int unsigned SEC_CNT_W = 8;
    localparam logic [3:0]  SEP_DEFAULT = 4'hF;

    typedef enum logic [PAGE_W-1:0] {
        P_TIME = 2'd0,
        P_DATE = 2'd1,
        P_WEEK = 2'd2
    } page_e;

endpackage

// File: rtl/disp_page_mux_sec_tick_gen.sv
// Free-running divider producing a one-cycle pulse once every CLK_FREQ clocks.
module sec_tick_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rstn,
    output logic sec_tick
);

    localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sec_tick = (cnt == TERM);

endmodule

// File: rtl/disp_page_mux.sv
// Display-page sequencer: snapshots RTC time/date, rotates TIME/DATE/WEEK pages,
// and blanks the display with separators when RTC reads stop arriving.
module disp_page_mux
    import disp_page_mux_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned NUM_PAGES = 3,
    parameter int unsigned DWELL_S   = 5,
    parameter int unsigned STALE_S   = 3,
    parameter logic [3:0]  SEP_CODE  = SEP_DEFAULT,
    parameter logic [7:0]  CENTURY   = 8'h20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_flag,
    input  logic        auto_en,
    input  logic        read_done,
    input  logic [23:0] time_data,
    input  logic [31:0] date_data,
    output logic [31:0] disp_data,
    output logic [1:0]  page,
    output logic        stale
);

    localparam logic [SEC_CNT_W-1:0] DWELL_LAST = SEC_CNT_W'(DWELL_S - 1);
    localparam logic [SEC_CNT_W-1:0] STALE_MAX  = SEC_CNT_W'(STALE_S);
    localparam page_e LAST_PAGE = (NUM_PAGES == 2) ? P_DATE : P_WEEK;

    logic                 sec_tick;
    logic                 dwell_exp;
    logic                 advance;
    logic [SEC_CNT_W-1:0] dwell_cnt;
    logic [SEC_CNT_W-1:0] stale_cnt;
    logic                 stale_q;
    logic [23:0]          snap_time;
    logic [31:0]          snap_date;
    logic [31:0]          fmt_data;
    logic [31:0]          disp_q;
    logic                 unused_date_pad;
    page_e                page_q;
    page_e                page_d;

    sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_sec_tick_gen (
        .clk      (clk),
        .rstn     (rstn),
        .sec_tick (sec_tick)
    );

    // Key and dwell expiry are OR-ed so a coincident pair yields a single step.
    assign dwell_exp = auto_en && sec_tick && (dwell_cnt == DWELL_LAST);
    assign advance   = key_flag || dwell_exp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            page_q <= P_TIME;
        end else begin
            page_q <= page_d;
        end
    end

    always_comb begin
        page_d = page_q;
        if (advance) begin
            case (page_q)
                P_TIME:  page_d = P_DATE;
                P_DATE:  page_d = (LAST_PAGE == P_DATE) ? P_TIME : P_WEEK;
                default: page_d = P_TIME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwell_cnt <= '0;
        end else if (!auto_en || advance) begin
            dwell_cnt <= '0;
        end else if (sec_tick) begin
            dwell_cnt <= dwell_cnt + SEC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stale_cnt <= '0;
            stale_q   <= 1'b1;
        end else if (read_done) begin
            stale_cnt <= '0;
            stale_q   <= 1'b0;
        end else if (sec_tick && (stale_cnt != STALE_MAX)) begin
            stale_cnt <= stale_cnt + SEC_CNT_W'(1);
            if (stale_cnt + SEC_CNT_W'(1) == STALE_MAX) begin
                stale_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_time <= '0;
            snap_date <= '0;
        end else if (read_done) begin
            snap_time <= time_data;
            snap_date <= date_data;
        end
    end

    always_comb begin
        fmt_data = {8{SEP_CODE}};
        case (page_q)
            P_TIME: fmt_data = {snap_time[23:16], SEP_CODE, snap_time[15:8], SEP_CODE,
                                snap_time[7:0]};
            P_DATE: fmt_data = {CENTURY, snap_date[31:24], snap_date[23:16], snap_date[15:8]};
            P_WEEK: fmt_data = {SEP_CODE, SEP_CODE, SEP_CODE, snap_date[3:0],
                                SEP_CODE, SEP_CODE, snap_time[7:0]};
            default: fmt_data = {8{SEP_CODE}};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_q <= {8{SEP_CODE}};
        end else begin
            disp_q <= stale_q ? {8{SEP_CODE}} : fmt_data;
        end
    end

    assign unused_date_pad = ^snap_date[7:4];

    assign disp_data = disp_q;
    assign page      = page_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_disp_page_mux.sv
// Randomized and directed check of disp_page_mux (3-page and 2-page builds) against a cycle model.
module tb_disp_page_mux;

    localparam int CF = 10;
    localparam int DW = 2;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key_flag;
    logic        auto_en;
    logic        read_done;
    logic [23:0] time_data;
    logic [31:0] date_data;
    logic [31:0] disp3, disp2;
    logic [1:0]  page3, page2;
    logic        stale3, stale2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    disp_page_mux #(.CLK_FREQ(CF), .NUM_PAGES(3), .DWELL_S(DW), .STALE_S(ST),
                    .SEP_CODE(4'hF), .CENTURY(8'h20)) u_dut3 (
        .clk(clk), .rstn(rstn), .key_flag(key_flag), .auto_en(auto_en),
        .read_done(read_done), .time_data(time_data), .date_data(date_data),
        .disp_data(disp3), .page(page3), .stale(stale3)
    );

    disp_page_mux #(.CLK_FREQ(CF), .NUM_PAGES(2), .DWELL_S(DW), .STALE_S(ST),
                    .SEP_CODE(4'hF), .CENTURY(8'h20)) u_dut2 (
        .clk(clk), .rstn(rstn), .key_flag(key_flag), .auto_en(auto_en),
        .read_done(read_done), .time_data(time_data), .date_data(date_data),
        .disp_data(disp2), .page(page2), .stale(stale2)
    );

    // Reference state: elapsed clocks in the current second, seconds on the
    // current page, seconds since the last read, and the page per build.
    int          m_tc, m_dw, m_sc;
    bit          m_st;
    logic [23:0] m_t;
    logic [31:0] m_d;
    int          m_pg[2];
    logic [31:0] m_disp[2];
    int          np[2] = '{3, 2};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input int pg, input logic [23:0] t, input logic [31:0] d);
        logic [7:0] hh, mi, ss, yy, mo, dd;
        logic [3:0] wd;
        hh = t[23:16]; mi = t[15:8]; ss = t[7:0];
        yy = d[31:24]; mo = d[23:16]; dd = d[15:8]; wd = d[3:0];
        case (pg)
            0:       return {hh, 4'hF, mi, 4'hF, ss};
            1:       return {8'h20, yy, mo, dd};
            default: return {12'hFFF, wd, 8'hFF, ss};
        endcase
    endfunction

    task automatic model_reset();
        m_tc = 0; m_dw = 0; m_sc = 0; m_st = 1'b1;
        m_t = '0; m_d = '0;
        for (int m = 0; m < 2; m++) begin
            m_pg[m] = 0;
            m_disp[m] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic model_step(input bit k, input bit a, input bit r,
                              input logic [23:0] t, input logic [31:0] d);
        bit tick, adv;
        tick = (m_tc == CF - 1);
        adv  = k || (a && tick && (m_dw + 1 == DW));
        m_tc = (m_tc + 1) % CF;
        for (int m = 0; m < 2; m++) begin
            m_disp[m] = m_st ? 32'hFFFF_FFFF : fmt(m_pg[m], m_t, m_d);
            if (adv) m_pg[m] = (m_pg[m] + 1) % np[m];
        end
        m_dw = (!a || adv) ? 0 : m_dw + int'(tick);
        if (r) begin
            m_sc = 0;
            m_st = 1'b0;
            m_t  = t;
            m_d  = d;
        end else if (tick) begin
            m_sc = (m_sc + 1 > ST) ? ST : m_sc + 1;
            if (m_sc == ST) m_st = 1'b1;
        end
    endtask

    task automatic check_all();
        check_eq("page3",  32'(page3),  32'(m_pg[0]));
        check_eq("page2",  32'(page2),  32'(m_pg[1]));
        check_eq("stale3", 32'(stale3), 32'(m_st));
        check_eq("stale2", 32'(stale2), 32'(m_st));
        check_eq("disp3",  disp3, m_disp[0]);
        check_eq("disp2",  disp2, m_disp[1]);
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic cycle(input bit k, input bit a, input bit r,
                         input logic [23:0] t, input logic [31:0] d);
        key_flag = k; auto_en = a; read_done = r; time_data = t; date_data = d;
        model_step(k, a, r, t, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit a);
        cycle(1'b0, a, 1'b0, 24'h0, 32'h0);
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_page3", 32'(page3), 32'd0);
        check_eq("rst_page2", 32'(page2), 32'd0);
        check_eq("rst_stale", 32'(stale3), 32'd1);
        check_eq("rst_disp",  disp3, 32'hFFFF_FFFF);
        key_flag = 1'b0; auto_en = 1'b0; read_done = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int  n;
        int  p0;
        bit  found;
        bit  a_lvl;
        rstn = 1'b0; key_flag = 1'b0; auto_en = 1'b0; read_done = 1'b0;
        time_data = '0; date_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_page",  32'(page3),  32'd0);
        check_eq("reset_stale", 32'(stale3), 32'd1);
        check_eq("reset_disp",  disp3, 32'hFFFF_FFFF);
        rstn = 1'b1;

        // Snapshot latency and manual page stepping.
        cycle(1'b0, 1'b0, 1'b1, 24'h123456, 32'h2407_1503);
        check_eq("stale_clear", 32'(stale3), 32'd0);
        idle(1'b0);
        check_eq("time_page", disp3, 32'h12F3_4F56);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
        check_eq("key1_page3", 32'(page3), 32'd1);
        idle(1'b0);
        check_eq("date_page3", disp3, 32'h2024_0715);
        check_eq("date_page2", disp2, 32'h2024_0715);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
        check_eq("key2_page3", 32'(page3), 32'd2);
        check_eq("key2_page2", 32'(page2), 32'd0);
        idle(1'b0);
        check_eq("week_page3", disp3, 32'hFFF3_FF56);
        check_eq("time_page2", disp2, 32'h12F3_4F56);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
        check_eq("key3_page3", 32'(page3), 32'd0);
        check_eq("key3_page2", 32'(page2), 32'd1);
        idle(1'b0);

        // Auto-rotate period, then a dropout of auto_en mid-dwell.
        n = 0; p0 = int'(page3);
        do begin idle(1'b1); n++; end while (int'(page3) == p0 && n < 100);
        check_eq("auto_first_seen", 32'(n < 100), 32'd1);
        n = 0; p0 = int'(page3);
        do begin idle(1'b1); n++; end while (int'(page3) == p0 && n < 100);
        check_eq("auto_period", 32'(n), 32'(CF * DW));
        repeat (12) idle(1'b1);
        repeat (5) idle(1'b0);
        n = 0; p0 = int'(page3);
        do begin idle(1'b1); n++; end while (int'(page3) == p0 && n < 100);
        check_eq("auto_restart_full_dwell", 32'(n > CF), 32'd1);

        // Key coincident with dwell expiry.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_tc == CF - 1 && m_dw + 1 == DW) begin
                p0 = int'(page3);
                cycle(1'b1, 1'b1, 1'b0, 24'h0, 32'h0);
                check_eq("coincident_adv", 32'(page3), 32'((p0 + 1) % 3));
                found = 1'b1;
            end else begin
                idle(1'b1);
            end
        end
        check_eq("coincident_found", 32'(found), 32'd1);

        // Stale timeout and recovery.
        cycle(1'b0, 1'b0, 1'b1, 24'h235959, 32'h2512_3106);
        repeat (31) idle(1'b0);
        check_eq("stale_set",  32'(stale3), 32'd1);
        check_eq("stale_disp", disp3, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 1'b1, 24'h010203, 32'h2601_0204);
        idle(1'b0);
        check_eq("stale_recover", 32'(disp3 != 32'hFFFF_FFFF), 32'd1);

        // Random traffic with a mid-run asynchronous reset.
        a_lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit k, r;
            if (i == 1500) async_reset();
            if ($urandom_range(0, 29) == 0) a_lvl = ~a_lvl;
            k = ($urandom_range(0, 7) == 0);
            r = ((i % 400) < 250) && ($urandom_range(0, 39) == 0);
            cycle(k, a_lvl, r, 24'($urandom), 32'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
